// File: rtl/rx_deserializer.sv
// UART receive deserializer: collects LSB-first data, parity and stop samples
// under the framing FSM's stage indicators and holds one word for the host.
module rx_deserializer #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int PARITY_TYPE      = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in,
   input  logic                        sampling_strobe,
   input  logic                        data_is_available,
   input  logic                        is_parity_stage,
   input  logic                        data_is_valid,
   output logic [INPUT_DATA_WIDTH-1:0] rx_data,
   output logic                        rx_data_valid,
   input  logic                        rx_data_ready,
   output logic                        parity_error,
   output logic                        framing_error,
   output logic                        overrun_error
);
   localparam int W  = INPUT_DATA_WIDTH;
   localparam int CW = $clog2(INPUT_DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(INPUT_DATA_WIDTH);
   localparam logic PODD = (PARITY_TYPE != 0);

   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    shift_q, shift_d;
   logic            parity_q;
   logic [W-1:0]    rx_data_q;
   logic            valid_q, perr_q, ferr_q, ovr_q;
   logic            perr_d;
   logic            d_evt, p_evt, s_evt, no_stage;

   assign d_evt    = sampling_strobe & data_is_available;
   assign p_evt    = sampling_strobe & is_parity_stage;
   assign s_evt    = sampling_strobe & data_is_valid;
   // Indicators are contiguous across a frame; a gap means it was abandoned.
   assign no_stage = ~(data_is_available | is_parity_stage | data_is_valid);

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = {serial_in, shift_q[W-1:1]};
      perr_d  = (^shift_q) ^ parity_q ^ PODD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= F_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         if (valid_q && rx_data_ready) valid_q <= 1'b0;
         case (state_q)
            F_IDLE: begin
               if (d_evt) begin
                  shift_q <= shift_d;
                  cnt_q   <= 1;
                  state_q <= F_DATA;
               end
            end
            F_DATA: begin
               if (d_evt) begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_d;
                  if (cnt_d == LAST) state_q <= F_PARITY;
               end else if (no_stage) begin
                  cnt_q   <= '0;
                  state_q <= F_IDLE;
               end
            end
            F_PARITY: begin
               if (p_evt) begin
                  parity_q <= serial_in;
                  state_q  <= F_STOP;
               end else if (no_stage) begin
                  cnt_q   <= '0;
                  state_q <= F_IDLE;
               end
            end
            F_STOP: begin
               if (s_evt) begin
                  // Commit overrides the handshake clear above.
                  rx_data_q <= shift_q;
                  perr_q    <= perr_d;
                  ferr_q    <= ~serial_in;
                  ovr_q     <= valid_q & ~rx_data_ready;
                  valid_q   <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= F_IDLE;
               end else if (no_stage) begin
                  cnt_q   <= '0;
                  state_q <= F_IDLE;
               end
            end
            default: state_q <= F_IDLE;
         endcase
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_data_valid = valid_q;
   assign parity_error  = perr_q;
   assign framing_error = ferr_q;
   assign overrun_error = ovr_q;
endmodule

// File: tb/tb_rx_deserializer.sv
// Bench for rx_deserializer: even- and odd-parity instances share one stimulus
// stream, checked against a frame-level model of the received word and flags.
module tb_rx_deserializer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic serial_in = 1'b1, strobe = 1'b0, dav = 1'b0, par = 1'b0, dvl = 1'b0, ready = 1'b0;
   logic [W-1:0] data0, data1;
   logic v0, v1, pe0, pe1, fe0, fe1, oe0, oe1;

   int checks = 0;
   int errors = 0;

   // frame-level model
   logic [W-1:0] m_data = '0;
   logic m_valid = 0, m_pe_even = 0, m_pe_odd = 0, m_fe = 0, m_oe = 0;

   always #5 clk = ~clk;

   rx_deserializer #(.INPUT_DATA_WIDTH(W), .PARITY_TYPE(0)) u_even (
      .clk(clk), .reset(reset), .serial_in(serial_in), .sampling_strobe(strobe),
      .data_is_available(dav), .is_parity_stage(par), .data_is_valid(dvl),
      .rx_data(data0), .rx_data_valid(v0), .rx_data_ready(ready),
      .parity_error(pe0), .framing_error(fe0), .overrun_error(oe0));

   rx_deserializer #(.INPUT_DATA_WIDTH(W), .PARITY_TYPE(1)) u_odd (
      .clk(clk), .reset(reset), .serial_in(serial_in), .sampling_strobe(strobe),
      .data_is_available(dav), .is_parity_stage(par), .data_is_valid(dvl),
      .rx_data(data1), .rx_data_valid(v1), .rx_data_ready(ready),
      .parity_error(pe1), .framing_error(fe1), .overrun_error(oe1));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_state(input string tag);
      checks++;
      if (v0 !== m_valid || v1 !== m_valid) begin
         errors++;
         $display("FAIL %s valid: got %b/%b want %b", tag, v0, v1, m_valid);
      end
      if (m_valid) begin
         checks++;
         if (data0 !== m_data || data1 !== m_data) begin
            errors++;
            $display("FAIL %s data: got %h/%h want %h", tag, data0, data1, m_data);
         end
         checks++;
         if (pe0 !== m_pe_even || pe1 !== m_pe_odd) begin
            errors++;
            $display("FAIL %s parity: got %b/%b want %b/%b", tag, pe0, pe1, m_pe_even, m_pe_odd);
         end
         checks++;
         if (fe0 !== m_fe || fe1 !== m_fe || oe0 !== m_oe || oe1 !== m_oe) begin
            errors++;
            $display("FAIL %s flags: got fe=%b/%b oe=%b/%b want fe=%b oe=%b",
                     tag, fe0, fe1, oe0, oe1, m_fe, m_oe);
         end
      end
   endtask

   // One 16-cycle bit period; strobe mid-bit. stage: 0 data, 1 parity, 2 stop.
   task automatic send_bit(input int stage, input logic val, input logic rdy);
      dav = (stage == 0);
      par = (stage == 1);
      dvl = (stage == 2);
      serial_in = val;
      tick(7);
      strobe = 1'b1;
      if (stage == 2) ready = rdy;
      tick(1);
      strobe = 1'b0;
      ready = 1'b0;
      tick(8);
   endtask

   task automatic idle_gap(input int n);
      dav = 0; par = 0; dvl = 0; serial_in = 1'b1;
      tick(n);
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic sbit,
                             input logic rdy, input string tag);
      int ones;
      for (int i = 0; i < W; i++) send_bit(0, d[i], 1'b0);
      send_bit(1, pbit, 1'b0);
      // stop bit, checked right before and right after the commit edge
      dav = 0; par = 0; dvl = 1; serial_in = sbit;
      tick(7);
      strobe = 1'b1;
      ready = rdy;
      check_state({tag, "_pre"});
      tick(1);
      strobe = 1'b0;
      ready = 1'b0;
      ones = pbit;
      for (int i = 0; i < W; i++) ones += d[i];
      m_oe = m_valid && !rdy;
      m_valid = 1;
      m_data = d;
      m_pe_even = (ones % 2) != 0;
      m_pe_odd  = (ones % 2) == 0;
      m_fe = !sbit;
      check_state(tag);
      tick(8);
      idle_gap(10);
   endtask

   task automatic consume(input string tag);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      if (m_valid) m_valid = 0;
      check_state(tag);
      checks++;
      if (data0 !== m_data) begin
         errors++;
         $display("FAIL %s hold: got %h want %h", tag, data0, m_data);
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks++;
      if ({data0, v0, pe0, fe0, oe0, data1, v1, pe1, fe1, oe1} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%b%b%b%b want 0", data0, v0, pe0, fe0, oe0);
      end
      reset = 1'b1;
      idle_gap(5);
      check_state("post_reset");
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, "a5");
      consume("a5_consume");
   endtask

   task automatic test_parity();
      send_frame(8'h01, 1'b0, 1'b1, 1'b0, "parity01");
      consume("parity01_consume");
   endtask

   task automatic test_framing();
      send_frame(8'h7E, 1'b0, 1'b0, 1'b0, "framing7e");
      consume("framing7e_consume");
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, "ovr11");
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, "ovr22");
      checks++;
      if (oe0 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b want 1", oe0);
      end
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, "ovr22_ready");
      checks++;
      if (oe0 !== 1'b0 || v0 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_ready: got oe=%b v=%b want oe=0 v=1", oe0, v0);
      end
      consume("ovr_consume");
   endtask

   task automatic test_abort();
      for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
      idle_gap(20);
      check_state("abort_gap");
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, "after_abort");
      consume("after_abort_consume");
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, "pre_rst");
      for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 1'b0);
      dav = 0;
      #2 reset = 1'b0;
      #1;
      m_valid = 0;
      checks++;
      if ({data0, v0, pe0, fe0, oe0, v1} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got %h/%b%b%b%b want 0", data0, v0, pe0, fe0, oe0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      idle_gap(10);
      check_state("midreset_after");
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0, "c3");
      consume("c3_consume");
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         send_frame(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
         if ($urandom_range(0, 2) == 0) consume("rand_consume");
         idle_gap($urandom_range(1, 20));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_overrun();
      test_abort();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
